win_banner: RTL

Parametrised "WIN" banner renderer for the end-of-game screen. It draws the W-I-N glyphs at a power-of-two pixel scale on the winning player's side, and animates them frame by frame: letters reveal one at a time, then the banner blinks. It sits in the pixel pipeline beside the other overlay generators, and its `out` is ORed into the final colour mux with a fixed 2-cycle latency relative to `x`/`y`.

---
 rtl/win_banner.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/win_banner.sv
// win_banner: renders the "WIN" end-of-game banner on the winner's side.
// A frame-driven controller reveals W, I, N in turn and then blinks the whole banner.
`ifndef PLAYER_1_COLOR
`define PLAYER_1_COLOR 3'd1
`endif
`ifndef PLAYER_2_COLOR
`define PLAYER_2_COLOR 3'd2
`endif
`ifndef WIN_TEXT_PLAYER_1_X_POS
`define WIN_TEXT_PLAYER_1_X_POS 100
`endif
`ifndef WIN_TEXT_PLAYER_2_X_POS
`define WIN_TEXT_PLAYER_2_X_POS 500
`endif
`ifndef WIN_TEXT_Y_POS
`define WIN_TEXT_Y_POS 50
`endif

module win_banner #(
  parameter int SCALE_LOG2    = 2,
  parameter int P1_X          = `WIN_TEXT_PLAYER_1_X_POS,
  parameter int P2_X          = `WIN_TEXT_PLAYER_2_X_POS,
  parameter int TEXT_Y        = `WIN_TEXT_Y_POS,
  parameter int REVEAL_FRAMES = 16,
  parameter int BLINK_FRAMES  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [2:0]  winner,
  input  logic        frame_tick,
  input  logic        blink_en,
  output logic        out,
  output logic        reveal_done
);

  typedef enum logic [1:0] {IDLE, REVEAL, HOLD} state_t;

  localparam logic [7:0] REVEAL_LAST = 8'(REVEAL_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);

  state_t      state_reg;
  logic [2:0]  win_q_reg;
  logic [1:0]  shown_reg;
  logic        vis_reg;
  logic [7:0]  fcnt_reg;
  logic        is_player;
  logic        restart;

  assign is_player = (winner == `PLAYER_1_COLOR) || (winner == `PLAYER_2_COLOR);
  assign restart   = is_player && ((state_reg == IDLE) || (winner != win_q_reg));

  // Winner changes outrank frame ticks, so a tick in a switch cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      win_q_reg   <= 3'd0;
      shown_reg   <= 2'd0;
      vis_reg     <= 1'b0;
      fcnt_reg    <= 8'd0;
      reveal_done <= 1'b0;
    end else begin
      reveal_done <= (state_reg == HOLD);
      if (!is_player) begin
        state_reg <= IDLE;
        shown_reg <= 2'd0;
        vis_reg   <= 1'b0;
        fcnt_reg  <= 8'd0;
      end else if (restart) begin
        win_q_reg <= winner;
        state_reg <= REVEAL;
        shown_reg <= 2'd1;
        vis_reg   <= 1'b1;
        fcnt_reg  <= 8'd0;
      end else begin
        case (state_reg)
          REVEAL: begin
            if (frame_tick) begin
              if (fcnt_reg == REVEAL_LAST) begin
                fcnt_reg  <= 8'd0;
                shown_reg <= shown_reg + 2'd1;
                if (shown_reg == 2'd2) state_reg <= HOLD;
              end else begin
                fcnt_reg <= fcnt_reg + 8'd1;
              end
            end
          end
          HOLD: begin
            if (!blink_en) begin
              vis_reg  <= 1'b1;
              fcnt_reg <= 8'd0;
            end else if (frame_tick) begin
              if (fcnt_reg == BLINK_LAST) begin
                fcnt_reg <= 8'd0;
                vis_reg  <= ~vis_reg;
              end else begin
                fcnt_reg <= fcnt_reg + 8'd1;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Stage 1: cell coordinates in 13-bit signed space so left/top misses never wrap.
  logic [12:0] x0;
  logic [12:0] dx;
  logic [12:0] dy;
  logic [11:0] cx_full;
  logic [11:0] cy_full;
  logic        in_grid;
  logic [2:0]  letter;

  assign x0      = (win_q_reg == `PLAYER_2_COLOR) ? 13'(P2_X) : 13'(P1_X);
  assign dx      = {1'b0, x} - x0;
  assign dy      = {1'b0, y} - 13'(TEXT_Y);
  assign cx_full = dx[11:0] >> SCALE_LOG2;
  assign cy_full = dy[11:0] >> SCALE_LOG2;
  assign in_grid = !dx[12] && !dy[12] && (cx_full < 12'd15) && (cy_full < 12'd7);

  always_comb begin
    letter = 3'b100;
    if (cx_full < 12'd7)       letter = 3'b001;
    else if (cx_full < 12'd9)  letter = 3'b010;
  end

  logic [3:0] cx_s1_reg;
  logic [2:0] cy_s1_reg;
  logic       in_grid_s1_reg;
  logic [2:0] letter_s1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_s1_reg      <= 4'd0;
      cy_s1_reg      <= 3'd0;
      in_grid_s1_reg <= 1'b0;
      letter_s1_reg  <= 3'd0;
    end else begin
      cx_s1_reg      <= cx_full[3:0];
      cy_s1_reg      <= cy_full[2:0];
      in_grid_s1_reg <= in_grid;
      letter_s1_reg  <= letter;
    end
  end

  // Glyph bitmap, bit i = column i; bit 15 pads the unused 16th column.
  function automatic logic [15:0] glyph_row(input logic [2:0] row);
    case (row)
      3'd0:    glyph_row = 16'b0100010101000001;
      3'd1:    glyph_row = 16'b0100110101001001;
      3'd2:    glyph_row = 16'b0100110101001001;
      3'd3:    glyph_row = 16'b0101010101001001;
      3'd4:    glyph_row = 16'b0110010101001001;
      3'd5:    glyph_row = 16'b0110010101001001;
      3'd6:    glyph_row = 16'b0100010100110110;
      default: glyph_row = 16'd0;
    endcase
  endfunction

  logic [2:0]  vis_mask;
  logic [15:0] row_bits;
  logic        lit;

  for (genvar gi = 0; gi < 3; gi++) begin : g_vis
    assign vis_mask[gi] = vis_reg && (shown_reg > 2'(gi));
  end

  assign row_bits = glyph_row(cy_s1_reg);
  assign lit      = row_bits[cx_s1_reg];

  // Stage 2 combines the registered geometry with the controller state of this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= 1'b0;
    else        out <= in_grid_s1_reg && lit && |(letter_s1_reg & vis_mask);
  end

endmodule
